// File: rtl/tlul_sram_slave_if.sv
// TL-UL Channel A / Channel D signal bundle between a master and the SRAM slave endpoint.
interface tlul_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [3:0]  a_mask;
    logic [31:0] a_address;
    logic [31:0] a_data;
    logic [2:0]  a_source;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [3:0]  d_size;
    logic [31:0] d_data;
    logic [2:0]  d_source;
    logic [1:0]  d_sink;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_mask, a_address, a_data, a_source,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_data, d_source, d_sink,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_mask, a_address, a_data, a_source,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_data, d_source, d_sink,
        input  d_ready
    );
endinterface

// File: rtl/tlul_sram_slave.sv
// TL-UL slave endpoint: word-addressed SRAM behind Channel A, single-entry registered
// Channel D response, saturating counter of rejected requests.
module tlul_sram_slave #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    tlul_if.slave       bus,
    output logic [15:0] err_count
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] OP_PUT_FULL  = 3'b000;
    localparam logic [2:0] OP_PUT_PART  = 3'b001;
    localparam logic [2:0] OP_GET       = 3'b100;
    localparam logic [2:0] OP_ACK       = 3'b000;
    localparam logic [2:0] OP_ACK_DATA  = 3'b001;

    // Opcode, size, natural alignment and address range must all hold.
    function automatic logic req_legal(
        input logic [2:0]  op,
        input logic [3:0]  size,
        input logic [31:0] addr
    );
        logic op_ok;
        logic align_ok;
        logic range_ok;
        op_ok = (op == OP_PUT_FULL) || (op == OP_PUT_PART) || (op == OP_GET);
        case (size)
            4'd0:    align_ok = 1'b1;
            4'd1:    align_ok = (addr[0] == 1'b0);
            4'd2:    align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
        range_ok = ((addr >> (AW + 2)) == 32'd0);
        return op_ok && align_ok && range_ok;
    endfunction

    logic [31:0] r_mem [DEPTH];

    logic        r_d_valid;
    logic [2:0]  r_d_opcode;
    logic [3:0]  r_d_size;
    logic [31:0] r_d_data;
    logic [2:0]  r_d_source;
    logic [15:0] r_err_count;

    logic        w_a_ready;
    logic        w_accept;
    logic        w_legal;
    logic        w_is_get;
    logic        w_mem_we;
    logic [AW-1:0] w_idx;
    logic        w_d_valid;
    logic [2:0]  w_d_opcode;
    logic [3:0]  w_d_size;
    logic [31:0] w_d_data;
    logic [2:0]  w_d_source;
    logic [15:0] w_err_count;
    logic        w_unused_param;

    // a_ready depends on d_ready combinationally so a draining response frees the slot.
    assign w_a_ready      = rst_n && (!r_d_valid || bus.d_ready);
    assign w_accept       = bus.a_valid && w_a_ready;
    assign w_legal        = req_legal(bus.a_opcode, bus.a_size, bus.a_address);
    assign w_is_get       = (bus.a_opcode == OP_GET);
    assign w_mem_we       = w_accept && w_legal && !w_is_get;
    assign w_idx          = bus.a_address[AW+1:2];
    assign w_unused_param = ^bus.a_param;

    // Next-state of the response register and the error counter.
    always_comb begin
        w_d_valid   = r_d_valid;
        w_d_opcode  = r_d_opcode;
        w_d_size    = r_d_size;
        w_d_data    = r_d_data;
        w_d_source  = r_d_source;
        w_err_count = r_err_count;
        if (w_accept) begin
            w_d_valid  = 1'b1;
            w_d_opcode = w_is_get ? OP_ACK_DATA : OP_ACK;
            w_d_size   = bus.a_size;
            w_d_source = bus.a_source;
            if (w_legal && w_is_get) begin
                w_d_data = r_mem[w_idx];
            end else begin
                w_d_data = 32'h0000_0000;
            end
            if (!w_legal && (r_err_count != 16'hFFFF)) begin
                w_err_count = r_err_count + 16'd1;
            end else begin
                w_err_count = r_err_count;
            end
        end else if (r_d_valid && bus.d_ready) begin
            w_d_valid = 1'b0;
        end else begin
            w_d_valid = r_d_valid;
        end
    end

    // Response register and error counter; a pending response is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'b000;
            r_d_size    <= 4'd0;
            r_d_data    <= 32'h0000_0000;
            r_d_source  <= 3'b000;
            r_err_count <= 16'd0;
        end else begin
            r_d_valid   <= w_d_valid;
            r_d_opcode  <= w_d_opcode;
            r_d_size    <= w_d_size;
            r_d_data    <= w_d_data;
            r_d_source  <= w_d_source;
            r_err_count <= w_err_count;
        end
    end

    // Byte-lane SRAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.a_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.a_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.a_ready  = w_a_ready;
    assign bus.d_valid  = r_d_valid;
    assign bus.d_opcode = r_d_opcode;
    assign bus.d_param  = 3'b000;
    assign bus.d_size   = r_d_size;
    assign bus.d_data   = r_d_data;
    assign bus.d_source = r_d_source;
    assign bus.d_sink   = 2'b00;
    assign err_count    = r_err_count;
endmodule
